// File: rtl/fetch_decode_queue_if.sv
// rtl/fetch_decode_queue_if.sv - fetch-to-decode queue handshake bundle
interface fetch_decode_queue_if #(
   parameter int INSTR_W = 32,
   parameter int PC_W    = 32,
   parameter int DEPTH   = 4,
   parameter int CNT_W   = $clog2(DEPTH) + 1
);
   logic               push_valid;
   logic [INSTR_W-1:0] push_instr;
   logic [PC_W-1:0]    push_pcplus4;
   logic               push_ready;
   logic               pop_ready;
   logic               out_valid;
   logic [INSTR_W-1:0] out_instr;
   logic [PC_W-1:0]    out_pcplus4;
   logic [CNT_W-1:0]   count;
   logic               full;
   logic               empty;

   modport master (
      output push_valid, push_instr, push_pcplus4, pop_ready,
      input  push_ready, out_valid, out_instr, out_pcplus4, count, full, empty
   );

   modport slave (
      input  push_valid, push_instr, push_pcplus4, pop_ready,
      output push_ready, out_valid, out_instr, out_pcplus4, count, full, empty
   );
endinterface

// File: rtl/fetch_decode_queue.sv
// rtl/fetch_decode_queue.sv - FWFT instruction queue between fetch and decode
module fetch_decode_queue #(
   parameter int INSTR_W = 32,
   parameter int PC_W    = 32,
   parameter int DEPTH   = 4,
   parameter int CNT_W   = $clog2(DEPTH) + 1
) (
   input  logic clk,
   input  logic reset,
   input  logic flush,
   fetch_decode_queue_if.slave q
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PTR_W-1:0]   wp;
   logic [PTR_W-1:0]   rp;
   logic [CNT_W-1:0]   cnt;
   logic [INSTR_W-1:0] mem_instr [DEPTH];
   logic [PC_W-1:0]    mem_pc    [DEPTH];

   logic is_full;
   logic is_empty;
   logic do_push;
   logic do_pop;

   assign is_full  = (cnt == FULL_CNT);
   assign is_empty = (cnt == '0);

   // Flush wins over both sides; full refuses push even if a pop frees a slot.
   assign do_push = q.push_valid && !is_full  && !flush;
   assign do_pop  = q.pop_ready  && !is_empty && !flush;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else if (flush) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop)  rp <= rp + 1'b1;
         if (do_push && !do_pop)
            cnt <= cnt + 1'b1;
         else if (do_pop && !do_push)
            cnt <= cnt - 1'b1;
      end
   end

   // Storage is never reset; the empty gating below keeps stale or X data off the outputs.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_instr[wp] <= q.push_instr;
         mem_pc[wp]    <= q.push_pcplus4;
      end
   end

   assign q.push_ready  = !is_full;
   assign q.out_valid   = !is_empty;
   assign q.out_instr   = is_empty ? '0 : mem_instr[rp];
   assign q.out_pcplus4 = is_empty ? '0 : mem_pc[rp];
   assign q.count       = cnt;
   assign q.full        = is_full;
   assign q.empty       = is_empty;
endmodule
